ip_tx_arbiter: RTL and testbench
================================

Name: ip_tx_arbiter

Overview:
Frame-granular round-robin arbiter that shares the single 4-bit nibble transmit path toward the MAC between several IPv4 frame sources (e.g. ICMP echo responder, UDP sender). It grants one requester at a time and holds the grant for a whole frame. It forwards that frame's nibbles with one-cycle registered latency, then enforces an inter-frame gap. Stalled frames are aborted after a timeout and flagged on err.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
IFG_NIBBLES, 24, idle cycles forced between frames (12 bytes); 0 allowed
STALL_MAX, 64, consecutive cycles without valid, while granted, before the frame is aborted (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (low = reset)
req  input  NUM_REQ  per-requester frame-pending request, level
din  input  4*NUM_REQ  per-requester nibble; requester i on bits [4i+3:4i]
valid  input  NUM_REQ  per-requester nibble valid; only honoured while grant[i]=1
last  input  NUM_REQ  marks final nibble of frame; only honoured with valid[i] and grant[i]
grant  output  NUM_REQ  one-hot registered grant
dout  output  4  forwarded nibble
dout_valid  output  1  dout carries frame data
busy  output  1  high in any state other than IDLE
err  output  1  one-cycle pulse on stall abort

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, grant=0, dout=0, dout_valid=0, busy=0, err=0, rr pointer=0, stall and gap counters=0. Asserting reset mid-frame aborts the frame immediately. No err pulse is generated for a reset abort.
- States: IDLE, XFER, GAP.
- IDLE: if any req bit is high, select the first set bit, searching upward from the rr pointer with wrap-around. On the next edge: grant=onehot(sel), state=XFER, busy=1, stall counter=0. If no req is high, remain in IDLE with outputs at 0.
- XFER: each cycle, dout<=din[sel], dout_valid<=valid[sel]. Latency is one cycle from valid input to dout_valid.
  - When valid[sel] is low, dout is held at 0.
  - Inputs from non-granted requesters are ignored entirely.
  - The stall counter increments on each cycle with valid[sel]=0 and clears on valid[sel]=1.
- XFER, end of frame: when valid[sel]&last[sel], the nibble is forwarded, then on the same edge grant<=0, rr pointer<=(sel+1) mod NUM_REQ, and state<=GAP (or IDLE if IFG_NIBBLES=0).
- XFER, stall abort: when the stall counter reaches STALL_MAX, on the same edge err<=1 for one cycle, grant<=0, dout_valid<=0, rr pointer advanced as for a normal end of frame, and state<=GAP.
- Dropping req during XFER does not end the frame; only last or a stall ends it.
- GAP: dout_valid=0 and grant=0 for exactly IFG_NIBBLES cycles (gap counter counts 0..IFG_NIBBLES-1), then IDLE. Requests arriving during GAP wait. Arbitration happens on the first IDLE cycle.
- Minimum spacing: the last dout_valid of one frame and the first possible grant of the next are separated by IFG_NIBBLES+1 cycles.
- Fairness: with all requesters permanently requesting, grants rotate 0,1,..,NUM_REQ-1,0.
- Counters: stall counter width clog2(STALL_MAX+1) and gap counter width clog2(IFG_NIBBLES+1); neither wraps.
- Single-nibble frame (first valid carries last) is legal and is handled as a normal end of frame.

Test Plan:
- Single requester: req[0]=1, sends 40 nibbles 0..F repeating, last on the 40th. Required: grant[0] one cycle after req. dout equals din delayed 1 cycle, 40 dout_valid cycles. grant drops after last. busy stays high for 24 more cycles, then returns low.
- Contention: req=2'b11 held; both send 8-nibble frames. Required grant order 0,1,0,1. Each new grant arrives 25 cycles after the previous frame's last input. Frames never interleave on dout.
- Non-granted noise: requester 1 toggles valid/din/last while requester 0 is granted. Required: dout shows only requester 0 data, and no early frame termination.
- Stall: after grant[0], send 3 nibbles then hold valid=0. Required: err pulses exactly once, 64 cycles after the last valid. grant[0] drops and the gap begins. The next grant goes to requester 1 if it is requesting.
- Mid-frame reset: pull rst low during XFER. Required: all outputs 0 immediately (asynchronous). After release: IDLE, rr pointer 0, and requester 0 wins if req=2'b11.
- IFG_NIBBLES=0, NUM_REQ=3, 1-nibble frames, req=3'b111. Required: grants rotate 0,1,2 with one IDLE cycle between frames.

Source files
------------

// File: rtl/ip_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one 4-bit nibble TX path between
// NUM_REQ frame sources, with inter-frame gap and stall abort. rst_i is async active-low.
module ip_tx_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int IFG_NIBBLES = 24,
    parameter int STALL_MAX   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [4*NUM_REQ-1:0] din_i,
    input  logic [NUM_REQ-1:0]   valid_i,
    input  logic [NUM_REQ-1:0]   last_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [3:0]           dout_o,
    output logic                 dout_valid_o,
    output logic                 busy_o,
    output logic                 err_o
);
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int STALL_W = $clog2(STALL_MAX + 1);
    localparam int GAP_W   = (IFG_NIBBLES > 0) ? $clog2(IFG_NIBBLES + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = (IFG_NIBBLES > 0) ? GAP_W'(IFG_NIBBLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [3:0]           dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 err_q, err_d;

    logic                 any_req;
    logic [IDX_W-1:0]     arb_idx;
    logic [IDX_W:0]       cand;
    logic [IDX_W-1:0]     rr_next;
    logic                 cur_valid;
    logic                 cur_last;
    logic [3:0]           cur_din;

    assign any_req   = |req_i;
    assign cur_valid = valid_i[sel_q];
    assign cur_last  = last_i[sel_q];
    assign cur_din   = din_i[{sel_q, 2'b00} +: 4];
    assign rr_next   = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

    // Scan offsets from high to low so the smallest offset from rr_q wins.
    always_comb begin
        arb_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_q} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) cand = cand - (IDX_W + 1)'(NUM_REQ);
            if (req_i[cand[IDX_W-1:0]]) arb_idx = cand[IDX_W-1:0];
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        state_d      = state_q;
        grant_d      = grant_q;
        sel_d        = sel_q;
        rr_d         = rr_q;
        stall_d      = stall_q;
        gap_d        = gap_q;
        dout_d       = '0;
        dout_valid_d = 1'b0;
        err_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    sel_d            = arb_idx;
                    stall_d          = '0;
                    state_d          = XFER;
                end
            end
            XFER: begin
                if (cur_valid) begin
                    dout_d       = cur_din;
                    dout_valid_d = 1'b1;
                    stall_d      = '0;
                    if (cur_last) begin
                        grant_d = '0;
                        rr_d    = rr_next;
                        gap_d   = '0;
                        state_d = (IFG_NIBBLES == 0) ? IDLE : GAP;
                    end
                end else if (stall_q == STALL_LAST) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    rr_d    = rr_next;
                    stall_d = '0;
                    gap_d   = '0;
                    state_d = (IFG_NIBBLES == 0) ? IDLE : GAP;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            sel_q        <= '0;
            rr_q         <= '0;
            stall_q      <= '0;
            gap_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            rr_q         <= rr_d;
            stall_q      <= stall_d;
            gap_q        <= gap_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            err_q        <= err_d;
        end
    end

    assign grant_o      = grant_q;
    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign busy_o       = (state_q != IDLE);
    assign err_o        = err_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Self-checking bench for ip_tx_arbiter: frame table with a nibble scoreboard,
// plus hand sequences for mid-frame reset and the zero-gap, three-requester build.
module tb_ip_tx_arbiter;
    localparam int IFG   = 24;
    localparam int STALL = 64;

    typedef struct {
        logic [1:0] req;
        logic [1:0] req_after;
        int         who;
        int         len;
        int         stall_after;
        bit         noise;
        bit         bubbles;
        logic [1:0] exp_grant;
        int         exp_wait;
        int         exp_end;
        int         exp_err;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [1:0] req_a, valid_a, last_a, grant_a;
    logic [7:0] din_a;
    logic [3:0] dout_a;
    logic       dout_valid_a, busy_a, err_a;

    logic [2:0]  req_b, valid_b, last_b, grant_b;
    logic [11:0] din_b;
    logic [3:0]  dout_b;
    logic        dout_valid_b, busy_b, err_b;

    int   n_vec   = 0;
    int   n_err   = 0;
    int   err_cnt = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[12];

    ip_tx_arbiter #(.NUM_REQ(2), .IFG_NIBBLES(IFG), .STALL_MAX(STALL)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .req_i(req_a), .din_i(din_a), .valid_i(valid_a),
        .last_i(last_a), .grant_o(grant_a), .dout_o(dout_a), .dout_valid_o(dout_valid_a),
        .busy_o(busy_a), .err_o(err_a)
    );

    ip_tx_arbiter #(.NUM_REQ(3), .IFG_NIBBLES(0), .STALL_MAX(STALL)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .req_i(req_b), .din_i(din_b), .valid_i(valid_b),
        .last_i(last_b), .grant_o(grant_b), .dout_o(dout_b), .dout_valid_o(dout_valid_b),
        .busy_o(busy_b), .err_o(err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each forwarded nibble must match the oldest driven one, exactly one cycle later.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (dout_valid_a) begin
                if (exp_q.size() == 0) begin
                    check("dout_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dout_data", 32'(dout_a), 32'(mon_e.data));
                    check("dout_latency", 32'(cyc), 32'(mon_e.due));
                end
            end else begin
                check("dout_idle_zero", 32'(dout_a), 32'd0);
            end
            if (err_a) err_cnt++;
        end
    end

    task automatic run_vec(input int id, input vec_t v);
        int         waited, nib, k, n_send, end_ticks, busy_cnt, err0, o;
        exp_t       e;
        logic [3:0] val;
        o      = 1 - v.who;
        err0   = err_cnt;
        req_a  = v.req;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (grant_a == '0 && waited < 300);
        check($sformatf("v%0d grant", id), 32'(grant_a), 32'(v.exp_grant));
        check($sformatf("v%0d grant_wait", id), 32'(waited), 32'(v.exp_wait));
        req_a  = v.req_after;
        n_send = (v.stall_after != 0) ? v.stall_after : v.len;
        nib    = 0;
        k      = 0;
        while (nib < n_send) begin
            valid_a = '0;
            last_a  = '0;
            din_a   = '0;
            if (v.noise) begin
                valid_a[o]      = 1'($urandom);
                last_a[o]       = 1'($urandom);
                din_a[o*4 +: 4] = 4'($urandom);
            end
            if (!(v.bubbles && (k % 3 == 2))) begin
                val                 = 4'(nib + 3 * v.who);
                valid_a[v.who]      = 1'b1;
                din_a[v.who*4 +: 4] = val;
                last_a[v.who]       = (v.stall_after == 0) && (nib == v.len - 1);
                e.data              = val;
                e.due               = cyc + 1;
                exp_q.push_back(e);
                nib++;
            end
            k++;
            tick();
        end
        valid_a = '0;
        last_a  = '0;
        din_a   = '0;
        if (v.stall_after != 0) begin
            end_ticks = 0;
            while (!err_a && end_ticks < 200) begin
                tick();
                end_ticks++;
            end
            check($sformatf("v%0d stall_to_err", id), 32'(end_ticks), 32'(v.exp_end));
        end
        check($sformatf("v%0d grant_drop", id), 32'(grant_a), 32'd0);
        busy_cnt = 0;
        while (busy_a && busy_cnt < 200) begin
            busy_cnt++;
            tick();
        end
        check($sformatf("v%0d gap_busy", id), 32'(busy_cnt), 32'(IFG));
        check($sformatf("v%0d err_pulses", id), 32'(err_cnt - err0), 32'(v.exp_err));
        check($sformatf("v%0d sb_drained", id), 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int waited, w;
        //           req    after  who len stl noise bub  grant  wait end err
        vecs[0]  = '{2'b11, 2'b11, 0,  8,  0,  1'b0, 1'b0, 2'b01, 1, 0,     0};
        vecs[1]  = '{2'b11, 2'b11, 1,  8,  0,  1'b0, 1'b0, 2'b10, 1, 0,     0};
        vecs[2]  = '{2'b11, 2'b11, 0,  8,  0,  1'b0, 1'b0, 2'b01, 1, 0,     0};
        vecs[3]  = '{2'b11, 2'b00, 1,  8,  0,  1'b0, 1'b0, 2'b10, 1, 0,     0};
        vecs[4]  = '{2'b01, 2'b00, 0,  40, 0,  1'b0, 1'b0, 2'b01, 1, 0,     0};
        vecs[5]  = '{2'b01, 2'b00, 0,  12, 0,  1'b1, 1'b0, 2'b01, 1, 0,     0};
        vecs[6]  = '{2'b01, 2'b11, 0,  10, 3,  1'b0, 1'b0, 2'b01, 1, STALL, 1};
        vecs[7]  = '{2'b11, 2'b00, 1,  5,  0,  1'b0, 1'b0, 2'b10, 1, 0,     0};
        vecs[8]  = '{2'b01, 2'b00, 0,  1,  0,  1'b0, 1'b0, 2'b01, 1, 0,     0};
        vecs[9]  = '{2'b10, 2'b00, 1,  10, 0,  1'b0, 1'b1, 2'b10, 1, 0,     0};
        vecs[10] = '{2'b11, 2'b00, 0,  3,  0,  1'b0, 1'b0, 2'b01, 1, 0,     0};
        vecs[11] = '{2'b11, 2'b00, 0,  2,  0,  1'b0, 1'b0, 2'b01, 1, 0,     0};

        rst_n   = 1'b0;
        req_a   = '0; valid_a = '0; last_a = '0; din_a = '0;
        req_b   = '0; valid_b = '0; last_b = '0; din_b = '0;
        #12;
        check("rst grant", 32'(grant_a), 32'd0);
        check("rst dout", 32'(dout_a), 32'd0);
        check("rst dout_valid", 32'(dout_valid_a), 32'd0);
        check("rst busy", 32'(busy_a), 32'd0);
        check("rst err", 32'(err_a), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i <= 10; i++) run_vec(i, vecs[i]);

        // Mid-frame reset: rr pointer sits at 1, so requester 1 is granted first.
        req_a  = 2'b11;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (grant_a == '0 && waited < 300);
        check("mrst pre_grant", 32'(grant_a), 32'd2);
        check("mrst pre_wait", 32'(waited), 32'd1);
        valid_a[1]  = 1'b1;
        din_a[7:4]  = 4'hA;
        tick();
        check("mrst pre_dout", 32'(dout_a), 32'hA);
        #2 rst_n = 1'b0;
        #1;
        check("mrst grant", 32'(grant_a), 32'd0);
        check("mrst dout", 32'(dout_a), 32'd0);
        check("mrst dout_valid", 32'(dout_valid_a), 32'd0);
        check("mrst busy", 32'(busy_a), 32'd0);
        check("mrst err", 32'(err_a), 32'd0);
        valid_a = '0;
        din_a   = '0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(11, vecs[11]);

        // Zero-gap build with three requesters and single-nibble frames.
        req_b = 3'b111;
        tick();
        for (int i = 0; i < 4; i++) begin
            w = i % 3;
            check($sformatf("b%0d grant", i), 32'(grant_b), 32'(1 << w));
            valid_b[w]       = 1'b1;
            last_b[w]        = 1'b1;
            din_b[w*4 +: 4]  = 4'(9 + i);
            tick();
            check($sformatf("b%0d dout_valid", i), 32'(dout_valid_b), 32'd1);
            check($sformatf("b%0d dout", i), 32'(dout_b), 32'(9 + i));
            check($sformatf("b%0d idle_grant", i), 32'(grant_b), 32'd0);
            check($sformatf("b%0d idle_busy", i), 32'(busy_b), 32'd0);
            valid_b = '0;
            last_b  = '0;
            din_b   = '0;
            tick();
        end
        req_b = '0;
        check("b err", 32'(err_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
